sv32_mem_responder: RTL and testbench
=====================================

Name: sv32_mem_responder

Overview:
Memory-side responder for the sv32 MMU physical bus (mem_valid/mem_ready/mem_wstrb/mem_addr[33:0]/mem_wdata/mem_rdata). It replaces the ad-hoc "ready one cycle after valid" model with a real target. It decodes the 34-bit physical address against a RAM window, inserts programmable wait states, and drives a synchronous single-port block RAM with byte write enables. It returns read data with a one-cycle ready pulse, flags out-of-window accesses, and counts completed reads and writes.

Parameters:
RAM_BASE, 34'h0_0000_0000, physical byte base address of the RAM window
RAM_AW, 16, RAM word-address width; window size = 4 << RAM_AW bytes (default 256 KiB)
WAIT_CYCLES, 0, extra cycles inserted before each RAM access (0..15)
RD_LATENCY, 1, block RAM read latency in cycles (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mem_valid  input  1  request from MMU, held until mem_ready
mem_ready  output  1  one-cycle completion pulse
mem_wstrb  input  4  byte write enables; 0 = read
mem_addr  input  34  physical byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_rdata  output  32  read data, valid while mem_ready=1
bus_error  output  1  pulses with mem_ready when the access fell outside the window
ram_en  output  1  RAM enable
ram_we  output  4  RAM byte write enables
ram_addr  output  RAM_AW  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, RD_LATENCY cycles after ram_en
rd_count  output  32  completed in-window reads, wraps at 2^32
wr_count  output  32  completed in-window writes, wraps at 2^32

Behaviour:
- Reset: state IDLE; mem_ready, bus_error, ram_en = 0; ram_we = 0; mem_rdata, ram_addr, ram_wdata = 0; rd_count, wr_count = 0. Reset aborts any in-flight access. No RAM write is issued after reset is asserted.
- FSM states: IDLE, WAIT, ACCESS, RDWAIT, RESP.
- IDLE: when mem_valid=1 and ready was not pulsed in the previous cycle, latch addr, wstrb and wdata, and compute in_window = (addr >= RAM_BASE) && (addr < RAM_BASE + (4<<RAM_AW)), using 35-bit compare, no overflow.
  - Not in window: go to RESP. No RAM access.
  - In window, WAIT_CYCLES>0: go to WAIT with the counter loaded to WAIT_CYCLES-1.
  - In window, WAIT_CYCLES=0: go to ACCESS.
- WAIT: decrement the counter; go to ACCESS when it reaches 0.
- ACCESS: ram_en=1 for exactly one cycle, ram_addr=(addr-RAM_BASE)>>2, ram_we=wstrb, ram_wdata=wdata.
  - Write: go to RESP.
  - Read: go to RDWAIT.
- RDWAIT: wait RD_LATENCY cycles, then register ram_rdata into mem_rdata and go to RESP.
- RESP: mem_ready=1 for one cycle. bus_error=!in_window. mem_rdata=32'h0 for out-of-window accesses and writes. rd_count or wr_count is incremented by 1 only for in-window accesses. Then go to IDLE.
- Latency from the accept cycle to mem_ready, with WAIT_CYCLES=0: in-window write = 2 cycles; read = 2+RD_LATENCY cycles; out-of-window = 1 cycle. Add WAIT_CYCLES to in-window cases.
- Back-to-back: the initiator deasserts mem_valid or presents a new request in the cycle after mem_ready. The responder ignores mem_valid in that cycle (one idle cycle per transaction), so no request is ever double-accepted.
- If mem_valid drops mid-transaction, the latched transaction still completes; a write commits and mem_ready still pulses.
- Inputs are sampled only at accept; later changes to addr, wdata or wstrb have no effect.
- Partial write (e.g. wstrb=4'b0011) modifies only the enabled lanes in RAM. The response is the same as for a full write.

Decomposition:
- Shared package/header (alongside the existing privilege/status headers): FSM state encodings, the 34-bit physical address width constant, and the bus_error code.
- One natural sub-module, sv32_mem_wait_ctr: a loadable down-counter producing a done flag, reused for both WAIT and RDWAIT.
- The block RAM stays external.

Test Plan:
- Write 0xAAAABBBB to 0x0_0001_0000 with wstrb=F, then read it back, WAIT_CYCLES=0, RD_LATENCY=1 -> write ready 2 cycles after accept, read ready 3 cycles after accept, rdata=0xAAAABBBB, wr_count=1, rd_count=1.
- Write 0x12345678, then write 0xFFFFFFFF with wstrb=4'b0101 to 0x0_0002_0000, then read -> rdata=0x12FF56FF.
- Read from 0x1_0000_0000 (outside the window) -> ready 1 cycle after accept, bus_error=1, rdata=0, ram_en never asserted, counters unchanged.
- WAIT_CYCLES=3, write then read at the last word 0x0_0003_FFFC -> ready at 5 and 6 cycles respectively, data correct. Address 0x0_0004_0000 -> bus_error.
- Assert reset during WAIT of a write -> ram_en stays 0, mem_ready stays 0, counters=0; the next read of that address returns the old value.
- 1000 back-to-back write/read pairs over the full window -> every compare matches, exactly one idle cycle between ready and the next accept, wr_count=rd_count=1000.

Source files
------------

// File: rtl/sv32_mem_responder_pkg.sv
// Shared definitions for the sv32 physical-bus memory responder:
// FSM encodings, physical address width and the bus error code.
package sv32_mem_responder_pkg;

  localparam int PADDR_W = 34;
  localparam int CTR_W   = 4;

  // Value driven on bus_error when an access misses the RAM window
  localparam logic BUS_ERR_OUT_OF_WINDOW = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RDWAIT,
    ST_RESP
  } mem_state_e;

endpackage

// File: rtl/sv32_mem_wait_ctr.sv
// Loadable down-counter with a terminal-count flag; shared by the
// wait-state and read-latency phases of the responder.
module sv32_mem_wait_ctr
  import sv32_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sv32_mem_responder.sv
// Memory-side target for the sv32 MMU physical bus: window decode, wait
// states, single-port block RAM with byte enables, access counters.
//
//   state  | meaning
//   IDLE   | waiting for a request; ignores the cycle right after mem_ready
//   WAIT   | programmable wait states before the RAM access
//   ACCESS | one-cycle RAM enable (write commits here)
//   RDWAIT | waiting out the RAM read latency
//   RESP   | one-cycle mem_ready pulse, counters update
module sv32_mem_responder
  import sv32_mem_responder_pkg::*;
#(
  parameter logic [PADDR_W-1:0] RAM_BASE    = '0,
  parameter int                 RAM_AW      = 16,
  parameter int                 WAIT_CYCLES = 0,
  parameter int                 RD_LATENCY  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [3:0]         mem_wstrb,
  input  logic [PADDR_W-1:0] mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               bus_error,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
);

  localparam int                 CMP_W    = PADDR_W + 1;
  localparam logic [CMP_W-1:0]   WIN_LO   = {1'b0, RAM_BASE};
  localparam logic [CMP_W-1:0]   WIN_HI   = WIN_LO + (CMP_W'(4) << RAM_AW);
  localparam logic [CTR_W-1:0]   WAIT_LD  = (WAIT_CYCLES > 0) ? CTR_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [CTR_W-1:0]   RD_LD    = CTR_W'(RD_LATENCY - 1);

  mem_state_e       state_q, state_d;
  logic             resp_q;
  logic [3:0]       wstrb_q;
  logic             in_window_q;
  logic             in_window_c;
  logic             accept;
  logic             ctr_load, ctr_dec, ctr_done;
  logic [CTR_W-1:0] ctr_val;

  // One spare bit keeps the upper bound from overflowing at the top of the space
  assign in_window_c = ({1'b0, mem_addr} >= WIN_LO) && ({1'b0, mem_addr} < WIN_HI);
  assign accept      = (state_q == ST_IDLE) && mem_valid && !resp_q;

  sv32_mem_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .done     (ctr_done)
  );

  always_comb begin
    state_d   = state_q;
    ctr_load  = 1'b0;
    ctr_val   = '0;
    ctr_dec   = 1'b0;
    mem_ready = 1'b0;
    bus_error = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ctr_load = 1'b1;
          ctr_val  = WAIT_LD;
          if (!in_window_c)         state_d = ST_RESP;
          else if (WAIT_CYCLES > 0) state_d = ST_WAIT;
          else                      state_d = ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (ctr_done) state_d = ST_ACCESS;
        else          ctr_dec = 1'b1;
      end
      ST_ACCESS: begin
        ram_en = 1'b1;
        ram_we = wstrb_q;
        if (wstrb_q != 4'b0000) begin
          state_d = ST_RESP;
        end else begin
          state_d  = ST_RDWAIT;
          ctr_load = 1'b1;
          ctr_val  = RD_LD;
        end
      end
      ST_RDWAIT: begin
        if (ctr_done) state_d = ST_RESP;
        else          ctr_dec = 1'b1;
      end
      ST_RESP: begin
        mem_ready = 1'b1;
        bus_error = in_window_q ? 1'b0 : BUS_ERR_OUT_OF_WINDOW;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      resp_q      <= 1'b0;
      wstrb_q     <= 4'b0000;
      in_window_q <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      mem_rdata   <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= (state_q == ST_RESP);
      if (accept) begin
        wstrb_q     <= mem_wstrb;
        ram_wdata   <= mem_wdata;
        ram_addr    <= RAM_AW'((mem_addr - RAM_BASE) >> 2);
        in_window_q <= in_window_c;
        mem_rdata   <= '0;
      end
      if ((state_q == ST_RDWAIT) && ctr_done) begin
        mem_rdata <= ram_rdata;
      end
      if ((state_q == ST_RESP) && in_window_q) begin
        if (wstrb_q != 4'b0000) wr_count <= wr_count + 1'b1;
        else                    rd_count <= rd_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sv32_mem_responder.sv
// Directed bench for sv32_mem_responder: two instances (no wait states and
// three wait states), each backed by a behavioural 1-cycle block RAM.
module tb_sv32_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ram_clr;
  logic [1:0]        mem_valid, mem_ready, bus_error, ram_en;
  logic [1:0][3:0]   mem_wstrb, ram_we;
  logic [1:0][33:0]  mem_addr;
  logic [1:0][31:0]  mem_wdata, mem_rdata, ram_wdata, ram_rdata, rd_count, wr_count;
  logic [1:0][15:0]  ram_addr;

  sv32_mem_responder #(.RAM_BASE(34'h0), .RAM_AW(16), .WAIT_CYCLES(0), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]),
    .mem_wstrb(mem_wstrb[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .bus_error(bus_error[0]), .ram_en(ram_en[0]),
    .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .rd_count(rd_count[0]), .wr_count(wr_count[0]));

  sv32_mem_responder #(.RAM_BASE(34'h0), .RAM_AW(16), .WAIT_CYCLES(3), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]),
    .mem_wstrb(mem_wstrb[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .bus_error(bus_error[1]), .ram_en(ram_en[1]),
    .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .rd_count(rd_count[1]), .wr_count(wr_count[1]));

  logic [31:0] ram_mem [2][65536];
  logic [31:0] ram_w;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_clr) begin
        for (int k = 0; k < 65536; k++) ram_mem[d][k] <= 32'h0;
      end else if (ram_en[d]) begin
        ram_w = ram_mem[d][ram_addr[d]];
        ram_rdata[d] <= ram_w;
        for (int b = 0; b < 4; b++)
          if (ram_we[d][b]) ram_w[8*b +: 8] = ram_wdata[d][8*b +: 8];
        ram_mem[d][ram_addr[d]] <= ram_w;
      end
    end
  end

  int cyc = 0;
  int en_cnt [2];
  int rdy_cnt [2];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d] === 1'b1)    en_cnt[d]  <= en_cnt[d] + 1;
      if (mem_ready[d] === 1'b1) rdy_cnt[d] <= rdy_cnt[d] + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int last_rdy [2];
  int exp_wr [2];
  int exp_rd [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string nm, output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      if (mem_ready[d] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no mem_ready within 64 cycles", nm);
    end
  endtask

  function automatic int accept_cycle(input int d, input int drive_cyc);
    return (drive_cyc > last_rdy[d] + 2) ? drive_cyc : last_rdy[d] + 2;
  endfunction

  task automatic txn(input int d, input logic [3:0] ws, input logic [33:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_data,
                     input int exp_lat, input logic exp_err, input string nm);
    int acc, en0;
    bit got;
    @(negedge clk);
    mem_valid[d] = 1'b1;
    mem_wstrb[d] = ws;
    mem_addr[d]  = a;
    mem_wdata[d] = wd;
    acc = accept_cycle(d, cyc);
    en0 = en_cnt[d];
    wait_ready(d, nm, got);
    mem_valid[d] = 1'b0;
    if (!got) return;
    check({nm, " latency"}, 64'(cyc - acc), 64'(exp_lat));
    check({nm, " bus_error"}, 64'(bus_error[d]), 64'(exp_err));
    check({nm, " rdata"}, 64'(mem_rdata[d]), 64'(exp_data));
    last_rdy[d] = cyc;
    if (!exp_err) begin
      if (ws != 4'b0000) exp_wr[d]++;
      else               exp_rd[d]++;
    end
    @(posedge clk); #1;
    check({nm, " ready pulse"}, 64'(mem_ready[d]), 64'(0));
    check({nm, " ram_en cycles"}, 64'(en_cnt[d] - en0), exp_err ? 64'(0) : 64'(1));
    check({nm, " wr_count"}, 64'(wr_count[d]), 64'(exp_wr[d]));
    check({nm, " rd_count"}, 64'(rd_count[d]), 64'(exp_rd[d]));
  endtask

  typedef struct {
    int          d;
    logic [3:0]  ws;
    logic [33:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dcyc, en0, rdy0;
    bit got;
    logic [15:0] word;
    logic [31:0] data;

    vecs.push_back('{0, 4'hF, 34'h0_0001_0000, 32'hAAAABBBB, 32'h00000000, 2, 1'b0});
    vecs.push_back('{0, 4'h0, 34'h0_0001_0000, 32'h00000000, 32'hAAAABBBB, 3, 1'b0});
    vecs.push_back('{0, 4'hF, 34'h0_0002_0000, 32'h12345678, 32'h00000000, 2, 1'b0});
    vecs.push_back('{0, 4'h5, 34'h0_0002_0000, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0});
    vecs.push_back('{0, 4'h0, 34'h0_0002_0000, 32'h00000000, 32'h12FF56FF, 3, 1'b0});
    vecs.push_back('{0, 4'h0, 34'h1_0000_0000, 32'h00000000, 32'h00000000, 1, 1'b1});
    vecs.push_back('{0, 4'hF, 34'h0_0004_0000, 32'hDEADBEEF, 32'h00000000, 1, 1'b1});
    vecs.push_back('{0, 4'h3, 34'h0_0003_FFFC, 32'hCAFEF00D, 32'h00000000, 2, 1'b0});
    vecs.push_back('{0, 4'h0, 34'h0_0003_FFFC, 32'h00000000, 32'h0000F00D, 3, 1'b0});
    vecs.push_back('{0, 4'h8, 34'h0_0001_0000, 32'h11223344, 32'h00000000, 2, 1'b0});
    vecs.push_back('{0, 4'h0, 34'h0_0001_0003, 32'h00000000, 32'h11AABBBB, 3, 1'b0});
    vecs.push_back('{1, 4'hF, 34'h0_0003_FFFC, 32'h5A5AA5A5, 32'h00000000, 5, 1'b0});
    vecs.push_back('{1, 4'h0, 34'h0_0003_FFFC, 32'h00000000, 32'h5A5AA5A5, 6, 1'b0});
    vecs.push_back('{1, 4'h0, 34'h0_0004_0000, 32'h00000000, 32'h00000000, 1, 1'b1});
    vecs.push_back('{1, 4'hF, 34'h3_FFFF_FFFC, 32'h01020304, 32'h00000000, 1, 1'b1});

    reset     = 1'b1;
    ram_clr   = 1'b1;
    mem_valid = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int d = 0; d < 2; d++) begin
      last_rdy[d] = -100;
      exp_wr[d]   = 0;
      exp_rd[d]   = 0;
      en_cnt[d]   = 0;
      rdy_cnt[d]  = 0;
    end
    @(posedge clk);
    ram_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset mem_ready", 64'(mem_ready[d]), 64'(0));
      check("reset bus_error", 64'(bus_error[d]), 64'(0));
      check("reset ram_en", 64'(ram_en[d]), 64'(0));
      check("reset ram_we", 64'(ram_we[d]), 64'(0));
      check("reset mem_rdata", 64'(mem_rdata[d]), 64'(0));
      check("reset ram_addr", 64'(ram_addr[d]), 64'(0));
      check("reset ram_wdata", 64'(ram_wdata[d]), 64'(0));
      check("reset counts", {rd_count[d], wr_count[d]}, 64'(0));
    end
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      txn(vecs[i].d, vecs[i].ws, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].lat,
          vecs[i].err, $sformatf("vec%0d", i));

    // valid drops and address/data change right after accept; the write must still commit
    @(negedge clk);
    mem_valid[0] = 1'b1;
    mem_wstrb[0] = 4'hF;
    mem_addr[0]  = 34'h0_0000_0100;
    mem_wdata[0] = 32'h0BADF00D;
    dcyc = cyc;
    acc  = accept_cycle(0, dcyc);
    repeat (acc - dcyc + 1) @(negedge clk);
    mem_valid[0] = 1'b0;
    mem_wstrb[0] = 4'h0;
    mem_addr[0]  = 34'h0_0000_0200;
    mem_wdata[0] = 32'h0;
    wait_ready(0, "drop write", got);
    if (got) begin
      check("drop write latency", 64'(cyc - acc), 64'(2));
      check("drop write bus_error", 64'(bus_error[0]), 64'(0));
      last_rdy[0] = cyc;
      exp_wr[0]++;
    end
    @(posedge clk); #1;
    txn(0, 4'h0, 34'h0_0000_0100, 32'h0, 32'h0BADF00D, 3, 1'b0, "drop readback");
    txn(0, 4'h0, 34'h0_0000_0200, 32'h0, 32'h00000000, 3, 1'b0, "drop other addr");

    // reset while the delayed instance sits in WAIT for a write
    @(negedge clk);
    mem_valid[1] = 1'b1;
    mem_wstrb[1] = 4'hF;
    mem_addr[1]  = 34'h0_0003_FFFC;
    mem_wdata[1] = 32'hBAD0BAD0;
    dcyc = cyc;
    acc  = accept_cycle(1, dcyc);
    en0  = en_cnt[1];
    rdy0 = rdy_cnt[1];
    repeat (acc - dcyc + 2) @(negedge clk);
    reset        = 1'b1;
    mem_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("reset-in-wait ram_en", 64'(en_cnt[1] - en0), 64'(0));
    check("reset-in-wait mem_ready", 64'(rdy_cnt[1] - rdy0), 64'(0));
    for (int d = 0; d < 2; d++) begin
      check("reset-in-wait counts", {rd_count[d], wr_count[d]}, 64'(0));
      exp_wr[d]   = 0;
      exp_rd[d]   = 0;
      last_rdy[d] = -100;
    end
    txn(1, 4'h0, 34'h0_0003_FFFC, 32'h0, 32'h5A5AA5A5, 6, 1'b0, "reset old value");

    // back-to-back write/read pairs spread over the whole window
    for (int i = 0; i < 1000; i++) begin
      word = 16'(i * 67);
      data = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      txn(0, 4'hF, {16'h0, word, 2'b00}, data, 32'h0, 2, 1'b0, "b2b write");
      txn(0, 4'h0, {16'h0, word, 2'b00}, 32'h0, data, 3, 1'b0, "b2b read");
    end
    check("b2b wr_count", 64'(wr_count[0]), 64'(1000));
    check("b2b rd_count", 64'(rd_count[0]), 64'(1000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
